coin_acceptor: RTL and testbench
================================

# coin_acceptor

Front-end stage ahead of the newspaper vending machine FSM. Turns two raw, asynchronous, bouncing coin-sensor lines (5-won and 10-won slots) into clean one-cycle coin codes on the 2-bit `coin` bus the vending machine consumes: 00 none, 01 five won, 10 ten won. Synchronizes and debounces each sensor, detects stuck or jammed sensors, and buffers coins in a small FIFO. Coins arriving together, or while the machine holds off acceptance, are delivered one per cycle and never merged.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples required to change a channel's stable level (legal range 2..255).
- `STUCK_CYCLES`, default 1000: consecutive stable-high cycles on either channel that raise `jam` (must exceed `DEBOUNCE_CYCLES`; counter saturates).
- `FIFO_DEPTH`, default 4: coin buffer entries (power of two, at least 2).
- `clk` input, 1 bit: single clock; all state on rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `sense_5` input, 1 bit: raw 5-won slot sensor, asynchronous, high while a coin passes.
- `sense_10` input, 1 bit: raw 10-won slot sensor, asynchronous.
- `out_en` input, 1 bit: downstream may accept a coin this cycle; low means hold coins in the FIFO.
- `clr_jam` input, 1 bit: synchronous one-cycle clear of `jam`.
- `coin` output, 2 bits: registered coin code; non-zero for exactly one cycle per delivered coin.
- `jam` output, 1 bit: sticky sensor fault flag.
- `reject` output, 1 bit: one-cycle pulse when a detected coin is dropped because the FIFO is full.
- `level` output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

## Operation
- Per channel, there is a 2-flop synchronizer, then a debounce counter. The counter resets whenever the synchronized sample equals the channel's stable level. It increments otherwise. Reaching `DEBOUNCE_CYCLES` flips the stable level and clears the counter. Debounce is symmetric for rise and fall.
- Coin event: the stable level rises 0->1. A second coin on the same channel needs the stable level to fall and rise again. Sensor bounce shorter than `DEBOUNCE_CYCLES` produces no event.
- Jam: any channel stable-high for `STUCK_CYCLES` consecutive cycles sets `jam`. Stable-high on both channels in the same cycle also sets `jam` immediately. `jam` is cleared only by `rst` or by `clr_jam` while both stable levels are low. If both conditions occur together, `clr_jam` loses to a set. While `jam` is high, events are ignored (not pushed, no `reject`). FIFO draining continues.
- Push: an event pushes its code (01 or 10) if there is space. If there is no space, it pulses `reject` and the FIFO is unchanged.
- Simultaneous events on both channels in one cycle (without jam): push 01, then 10, in that order in the same cycle. If only one slot is free, push 10 and pulse `reject` for the 01. If no slot is free, pulse `reject` once.
- Pop: when the FIFO is non-empty and `out_en` is high, pop the head and register it onto `coin` next edge. Otherwise `coin` is 00. Throughput is one coin per cycle.
- Push and pop in the same cycle: both occur. A full FIFO with a simultaneous pop still rejects, because fullness is judged before the pop.
- `level` reflects pushes and pops after each edge. It never exceeds `FIFO_DEPTH`.

## Timing
- Reset values: `coin`=00, `jam`=0, `reject`=0, `level`=0. The synchronizers, stable levels, counters and FIFO pointers are all 0.
- Reset mid-operation flushes buffered coins with no output. A sensor held high through reset release is treated as a new coin after full debounce.
- Latency, with an empty FIFO and `out_en` high: if the sensor is first sampled high at edge k and held, `coin` is non-zero during the cycle after edge k+DEBOUNCE_CYCLES+3. With defaults this is edge k+7.
- `reject` is asserted in the cycle following the event edge, aligned with when the push would have updated `level`.
- `jam` from a stuck sensor asserts at the edge where the stable-high run reaches `STUCK_CYCLES`.

## Test plan
- Clean 5-won pulse (20 cycles high), defaults -> `coin`=01 for exactly 1 cycle, 7 cycles after the first high sample. `level` returns to 0.
- 5-won sensor bouncing (1-cycle high/low glitches for 12 cycles, then steady high for 10 cycles) -> exactly one 01. Glitch-only stimulus -> no coin.
- Both sensors rise in the same cycle (held 6 cycles, then released) -> `jam`=1, no coins. `clr_jam` while both are low clears it; a following 10-won pulse yields `coin`=10.
- `out_en`=0, then five 10-won pulses -> `level` reaches 4, the fifth pulse produces a `reject` pulse. Raising `out_en` gives `coin`=10 for 4 consecutive cycles.
- 5-won pulse followed by a 10-won pulse (matching the machine's 15-won sale) -> `coin` sequence 01 then 10, each for one cycle. Order is preserved.
- `sense_10` held high for 1000+ cycles -> `jam` asserts at the `STUCK_CYCLES` point. Asserting `rst` mid-stream with `level`=3 -> all outputs 0 and no buffered coins emitted afterwards.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin sensor front end: sync, debounce, jam detect and a small coin FIFO
// feeding one-cycle coin codes to the vending machine.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES = 1000,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sense_5,
  input  logic          sense_10,
  input  logic          out_en,
  input  logic          clr_jam,
  output logic [1:0]    coin,
  output logic          jam,
  output logic          reject,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    stable_q;
  logic [1:0]    stuck_hit;
  logic [1:0]    ev;
  logic [7:0]    dcnt [2];
  logic [SW-1:0] scnt [2];
  logic          jam_set;
  logic          jam_clr;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [LW-1:0] cnt;
  logic [LW-1:0] free;
  logic [1:0]    npush;
  logic [1:0]    d0;
  logic [1:0]    d1;
  logic          rej;
  logic          pop;

  // channel 0 is the 5-won slot, channel 1 the 10-won slot
  assign raw = {sense_10, sense_5};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int c = 0; c < 2; c++) begin
        dcnt[c] <= '0;
        scnt[c] <= '0;
      end
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int c = 0; c < 2; c++) begin
        if (sync2[c] == stable[c]) begin
          dcnt[c] <= '0;
        end else if (dcnt[c] == 8'(DEBOUNCE_CYCLES - 1)) begin
          stable[c] <= ~stable[c];
          dcnt[c]   <= '0;
        end else begin
          dcnt[c] <= dcnt[c] + 8'd1;
        end
        if (!stable[c]) begin
          scnt[c] <= '0;
        end else if (scnt[c] != SW'(STUCK_CYCLES)) begin
          scnt[c] <= scnt[c] + SW'(1);
        end
      end
    end
  end

  always_comb begin
    stuck_hit = '0;
    for (int c = 0; c < 2; c++) begin
      stuck_hit[c] = stable[c] && (scnt[c] == SW'(STUCK_CYCLES - 1));
    end
  end

  assign jam_set = (&stable) | (|stuck_hit);
  assign jam_clr = clr_jam & ~(|stable);
  // events are dropped while jammed, including the cycle that sets jam
  assign ev = stable & ~stable_q & {2{~(jam | jam_set)}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jam <= 1'b0;
    end else if (jam_set) begin
      jam <= 1'b1;
    end else if (jam_clr) begin
      jam <= 1'b0;
    end
  end

  assign free = LW'(FIFO_DEPTH) - cnt;
  assign pop  = out_en && (cnt != '0);

  always_comb begin
    npush = 2'd0;
    d0    = 2'b00;
    d1    = 2'b00;
    rej   = 1'b0;
    unique case (ev)
      2'b11: begin
        if (free >= LW'(2)) begin
          npush = 2'd2;
          d0    = 2'b01;
          d1    = 2'b10;
        end else if (free == LW'(1)) begin
          npush = 2'd1;
          d0    = 2'b10;
          rej   = 1'b1;
        end else begin
          rej = 1'b1;
        end
      end
      2'b01, 2'b10: begin
        if (free != '0) begin
          npush = 2'd1;
          d0    = ev;
        end else begin
          rej = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (npush != 2'd0) mem[wr] <= d0;
    if (npush == 2'd2) mem[wr + AW'(1)] <= d1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr     <= '0;
      rd     <= '0;
      cnt    <= '0;
      coin   <= 2'b00;
      reject <= 1'b0;
    end else begin
      wr     <= wr + AW'(npush);
      rd     <= rd + AW'(pop);
      cnt    <= cnt + LW'(npush) - LW'(pop);
      coin   <= pop ? mem[rd] : 2'b00;
      reject <= rej;
    end
  end

  assign level = cnt;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: vector table for single pulses plus
// hand sequences for bounce, jam, back-pressure, ordering, stuck and reset.
module tb_coin_acceptor;

  logic       clk;
  logic       rst;
  logic       sense_5;
  logic       sense_10;
  logic       out_en;
  logic       clr_jam;
  logic [1:0] coin;
  logic       jam;
  logic       reject;
  logic [2:0] level;

  int total;
  int passed;
  int n5;
  int n10;
  int nbad;
  int nrej;
  int log_q[$];

  coin_acceptor dut (
    .clk(clk),
    .rst(rst),
    .sense_5(sense_5),
    .sense_10(sense_10),
    .out_en(out_en),
    .clr_jam(clr_jam),
    .coin(coin),
    .jam(jam),
    .reject(reject),
    .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] sense;
    int         hold;
    int         exp_code;
    int         exp_n;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    if (coin == 2'b01) begin
      n5++;
      log_q.push_back(1);
    end else if (coin == 2'b10) begin
      n10++;
      log_q.push_back(2);
    end else if (coin == 2'b11) begin
      nbad++;
    end
    if (reject) nrej++;
  endtask

  task automatic drive(input logic [1:0] s, input int n);
    {sense_10, sense_5} = s;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clr();
    clr_jam = 1'b1;
    step();
    clr_jam = 1'b0;
  endtask

  vec_t vecs[5];
  int   c0;
  int   r0;
  int   lat;

  initial begin
    total = 0; passed = 0; n5 = 0; n10 = 0; nbad = 0; nrej = 0;
    rst = 1'b1; sense_5 = 1'b0; sense_10 = 1'b0;
    out_en = 1'b1; clr_jam = 1'b0;
    vecs[0] = '{2'b01, 20, 1, 1};
    vecs[1] = '{2'b10, 20, 2, 1};
    vecs[2] = '{2'b01, 3, 0, 0};
    vecs[3] = '{2'b10, 4, 2, 1};
    vecs[4] = '{2'b01, 2, 0, 0};

    step();
    step();
    chk("reset_coin", int'(coin), 0);
    chk("reset_jam", int'(jam), 0);
    chk("reset_reject", int'(reject), 0);
    chk("reset_level", int'(level), 0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      log_q.delete();
      c0  = n5 + n10;
      lat = -1;
      {sense_10, sense_5} = vecs[i].sense;
      for (int t = 1; t <= vecs[i].hold + 16; t++) begin
        step();
        if (t == vecs[i].hold) {sense_10, sense_5} = 2'b00;
        if (lat < 0 && n5 + n10 != c0) lat = t;
      end
      chk($sformatf("vec%0d_count", i), n5 + n10 - c0, vecs[i].exp_n);
      if (vecs[i].exp_n > 0) begin
        chk($sformatf("vec%0d_code", i), log_q.size() > 0 ? log_q[0] : 0,
            vecs[i].exp_code);
        chk($sformatf("vec%0d_latency", i), lat, 8);
      end
      chk($sformatf("vec%0d_level", i), int'(level), 0);
    end

    c0 = n5;
    for (int i = 0; i < 12; i++) drive({1'b0, i % 2 == 0}, 1);
    drive(2'b01, 10);
    drive(2'b00, 16);
    chk("bounce_then_steady", n5 - c0, 1);
    c0 = n5;
    for (int i = 0; i < 12; i++) drive({1'b0, i % 2 == 0}, 1);
    drive(2'b00, 16);
    chk("glitch_only", n5 - c0, 0);

    c0 = n5 + n10;
    drive(2'b11, 6);
    drive(2'b00, 16);
    chk("both_jam", int'(jam), 1);
    chk("both_no_coin", n5 + n10 - c0, 0);
    pulse_clr();
    chk("clr_jam_low", int'(jam), 0);
    c0 = n10;
    drive(2'b10, 20);
    drive(2'b00, 16);
    chk("after_clr_10", n10 - c0, 1);

    out_en = 1'b0;
    c0 = n5 + n10;
    r0 = nrej;
    for (int p = 0; p < 5; p++) begin
      drive(2'b10, 10);
      drive(2'b00, 10);
    end
    chk("full_level", int'(level), 4);
    chk("full_reject", nrej - r0, 1);
    chk("held_no_coin", n5 + n10 - c0, 0);
    out_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("drain%0d", i), int'(coin), 2);
    end
    step();
    chk("drain_done", int'(coin), 0);
    chk("drain_level", int'(level), 0);

    log_q.delete();
    drive(2'b01, 10);
    drive(2'b10, 10);
    drive(2'b00, 20);
    chk("order_n", log_q.size(), 2);
    chk("order_first", log_q.size() > 0 ? log_q[0] : 0, 1);
    chk("order_second", log_q.size() > 1 ? log_q[1] : 0, 2);

    out_en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      drive(2'b01, 10);
      drive(2'b00, 10);
    end
    chk("pre_reset_level", int'(level), 3);
    out_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_coin", int'(coin), 0);
    chk("midrst_jam", int'(jam), 0);
    chk("midrst_reject", int'(reject), 0);
    chk("midrst_level", int'(level), 0);
    step();
    rst = 1'b0;
    c0 = n5 + n10;
    drive(2'b00, 20);
    chk("post_rst_no_coin", n5 + n10 - c0, 0);

    c0 = n10;
    {sense_10, sense_5} = 2'b10;
    for (int t = 1; t <= 1010; t++) begin
      step();
      if (t == 1005) chk("stuck_before", int'(jam), 0);
      if (t == 1006) chk("stuck_at", int'(jam), 1);
    end
    pulse_clr();
    chk("clr_while_high", int'(jam), 1);
    drive(2'b00, 16);
    chk("jam_sticky", int'(jam), 1);
    pulse_clr();
    chk("clr_after_release", int'(jam), 0);
    chk("stuck_one_coin", n10 - c0, 1);
    chk("never_code_11", nbad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
